reg_file_unit: RTL and testbench

REG_FILE_UNIT -- requirements
Module: reg_file

---
 rtl/reg_file_unit.sv | 75 +++++++
 tb/tb_reg_file_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_unit.sv
// Eight-entry register file with two combinational read ports and an internal
// return-address LIFO that pushes a PC value and pops it into a register.
module reg_file_unit #(
  parameter int DATA_W      = 32,
  parameter int NREGS       = 8,
  parameter int STACK_DEPTH = 16,
  parameter int PC_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regwrite,
  input  logic              push,
  input  logic              pop,
  input  logic [PC_W-1:0]   stack_pc,
  input  logic [2:0]        rs1,
  input  logic [2:0]        rs2,
  input  logic [2:0]        ws,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int SI_W = $clog2(STACK_DEPTH);

  logic [DATA_W-1:0] r_regs  [NREGS];
  logic [PC_W-1:0]   r_stack [STACK_DEPTH];
  logic [SP_W-1:0]   r_sp;

  logic              w_full;
  logic              w_empty;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [SP_W-1:0]   w_sp_dec;
  logic [SI_W-1:0]   w_push_idx;
  logic [SI_W-1:0]   w_top_idx;
  logic [DATA_W-1:0] w_pop_data;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  // Simultaneous push and pop cancel each other; regwrite then acts alone.
  assign w_push_ok  = push & ~pop & ~w_full;
  assign w_pop_ok   = pop & ~push & ~w_empty;
  assign w_sp_dec   = r_sp - SP_W'(1);
  assign w_push_idx = r_sp[SI_W-1:0];
  assign w_top_idx  = w_sp_dec[SI_W-1:0];
  assign w_pop_data = DATA_W'(r_stack[w_top_idx]);

  assign rd1 = r_regs[rs1];
  assign rd2 = r_regs[rs2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      for (int j = 0; j < STACK_DEPTH; j++) begin
        r_stack[j] <= '0;
      end
      r_sp <= '0;
    end else begin
      if (w_pop_ok) begin
        r_regs[ws] <= w_pop_data;
        r_sp       <= w_sp_dec;
      end else if (regwrite) begin
        r_regs[ws] <= wd;
      end
      if (w_push_ok) begin
        r_stack[w_push_idx] <= stack_pc;
        r_sp                <= r_sp + SP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_reg_file_unit.sv
// Scoreboard bench for reg_file_unit: a behavioural model tracks registers and
// the LIFO, popped values are queued at stimulus time and compared on readback.
module tb_reg_file_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        regwrite = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic [7:0]  stack_pc = '0;
  logic [2:0]  rs1 = '0;
  logic [2:0]  rs2 = '0;
  logic [2:0]  ws = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [8];
  logic [7:0]  m_stack [$];
  logic [31:0] exp_q [$];

  reg_file_unit #(.DATA_W(32), .NREGS(8), .STACK_DEPTH(16), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .regwrite(regwrite), .push(push), .pop(pop),
    .stack_pc(stack_pc), .rs1(rs1), .rs2(rs2), .ws(ws), .wd(wd),
    .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_stack.delete();
    exp_q.delete();
  endtask

  // Advance the model on the current inputs, clock once, then drop requests.
  task automatic tick();
    bit          pu_ok;
    bit          po_ok;
    logic [31:0] v;
    if (reset) begin
      pu_ok = push && !pop && (m_stack.size() < 16);
      po_ok = pop && !push && (m_stack.size() > 0);
      if (po_ok) begin
        v = {24'h0, m_stack.pop_back()};
        m_regs[ws] = v;
        exp_q.push_back(v);
      end else if (regwrite) begin
        m_regs[ws] = wd;
      end
      if (pu_ok) m_stack.push_back(stack_pc);
    end
    @(posedge clk);
    #1;
    regwrite = 1'b0;
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    rs1 = 3'd0;
    rs2 = 3'd1;
    #2;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: rd1=%h rd2=%h required 0 0", rd1, rd2);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i);
      #1;
      checks++;
      if (rd1 !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h required 0", i, rd1);
      end
    end
  endtask

  task automatic test_write();
    regwrite = 1'b1;
    ws = 3'd2;
    wd = 32'hDEADBEEF;
    rs1 = 3'd2;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      errors++;
      $display("FAIL write_before_edge: got %h required 0", rd1);
    end
    tick();
    checks++;
    if (rd1 !== 32'hDEADBEEF || rd1 !== m_regs[2]) begin
      errors++;
      $display("FAIL write_after_edge: got %h required %h", rd1, m_regs[2]);
    end
    regwrite = 1'b1;
    ws = 3'd0;
    wd = 32'h12345678;
    tick();
    rs2 = 3'd0;
    #1;
    checks++;
    if (rd2 !== 32'h12345678) begin
      errors++;
      $display("FAIL write_r0: got %h required 12345678", rd2);
    end
  endtask

  task automatic test_stack_pop();
    logic [31:0] e;
    push = 1'b1;
    stack_pc = 8'd35;
    tick();
    pop = 1'b1;
    ws = 3'd1;
    regwrite = 1'b0;
    wd = 32'd25;
    tick();
    rs2 = 3'd1;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (rd2 !== e || rd2 !== 32'd35) begin
      errors++;
      $display("FAIL pop_35: got %0d required %0d", rd2, e);
    end
    push = 1'b1;
    stack_pc = 8'd36;
    tick();
    pop = 1'b1;
    ws = 3'd1;
    regwrite = 1'b1;
    wd = 32'd25;
    tick();
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (rd2 !== e || rd2 !== 32'd36) begin
      errors++;
      $display("FAIL pop_priority: got %0d required %0d", rd2, e);
    end
  endtask

  task automatic test_empty_pop();
    logic [31:0] e;
    pop = 1'b1;
    regwrite = 1'b1;
    ws = 3'd3;
    wd = 32'd7;
    tick();
    rs1 = 3'd3;
    #1;
    checks++;
    if (rd1 !== 32'd7 || rd1 !== m_regs[3]) begin
      errors++;
      $display("FAIL empty_pop_write: got %0d required 7", rd1);
    end
    push = 1'b1;
    stack_pc = 8'd5;
    tick();
    pop = 1'b1;
    ws = 3'd4;
    tick();
    pop = 1'b1;
    ws = 3'd4;
    tick();
    rs1 = 3'd4;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (rd1 !== e || rd1 !== 32'd5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL empty_sp_zero: got %0d required %0d", rd1, e);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] e;
    for (int i = 1; i <= 17; i++) begin
      push = 1'b1;
      stack_pc = 8'(i);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      ws = 3'd5;
      tick();
      rs1 = 3'd5;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      checks++;
      if (rd1 !== e || rd1 !== 32'(16 - i)) begin
        errors++;
        $display("FAIL overflow_pop%0d: got %0d required %0d", i, rd1, 16 - i);
      end
    end
    pop = 1'b1;
    ws = 3'd5;
    tick();
    #1;
    checks++;
    if (rd1 !== 32'd1 || rd1 !== m_regs[5]) begin
      errors++;
      $display("FAIL overflow_drained: got %0d required 1", rd1);
    end
  endtask

  task automatic test_push_pop();
    logic [31:0] e;
    push = 1'b1;
    stack_pc = 8'd11;
    tick();
    push = 1'b1;
    pop = 1'b1;
    stack_pc = 8'd9;
    regwrite = 1'b1;
    ws = 3'd6;
    wd = 32'h66;
    tick();
    rs1 = 3'd6;
    #1;
    checks++;
    if (rd1 !== 32'h66) begin
      errors++;
      $display("FAIL push_pop_write: got %h required 66", rd1);
    end
    pop = 1'b1;
    ws = 3'd7;
    tick();
    rs1 = 3'd7;
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    checks++;
    if (rd1 !== e || rd1 !== 32'd11) begin
      errors++;
      $display("FAIL push_pop_sp: got %0d required %0d", rd1, e);
    end
    pop = 1'b1;
    regwrite = 1'b1;
    ws = 3'd7;
    wd = 32'h77;
    tick();
    #1;
    checks++;
    if (rd1 !== 32'h77) begin
      errors++;
      $display("FAIL push_pop_empty_after: got %h required 77", rd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      regwrite = 1'b1;
      ws = 3'(i);
      wd = $urandom;
      push = 1'b1;
      stack_pc = 8'(100 + i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      rs1 = 3'(i);
      rs2 = 3'(7 - i);
      #1;
      checks++;
      if (rd1 !== m_regs[i] || rd2 !== m_regs[7 - i]) begin
        errors++;
        $display("FAIL b2b_read%0d: rd1=%h rd2=%h required %h %h",
                 i, rd1, rd2, m_regs[i], m_regs[7 - i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      ws = 3'(i);
      tick();
      rs2 = 3'(i);
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      checks++;
      if (rd2 !== e || rd2 !== 32'(107 - i)) begin
        errors++;
        $display("FAIL b2b_pop%0d: got %0d required %0d", i, rd2, 107 - i);
      end
    end
  endtask

  task automatic test_mid_reset();
    regwrite = 1'b1;
    ws = 3'd1;
    wd = 32'hAAAA;
    push = 1'b1;
    stack_pc = 8'd20;
    tick();
    regwrite = 1'b1;
    ws = 3'd2;
    wd = 32'hBBBB;
    push = 1'b1;
    stack_pc = 8'd21;
    tick();
    rs1 = 3'd1;
    rs2 = 3'd2;
    #1;
    checks++;
    if (rd1 !== m_regs[1] || rd2 !== m_regs[2]) begin
      errors++;
      $display("FAIL mid_pre: rd1=%h rd2=%h required %h %h", rd1, rd2, m_regs[1], m_regs[2]);
    end
    @(negedge clk);
    #2;
    regwrite = 1'b1;
    ws = 3'd1;
    wd = 32'h1234;
    push = 1'b1;
    stack_pc = 8'd22;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_async: rd1=%h rd2=%h required 0 0", rd1, rd2);
    end
    tick();
    checks++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      errors++;
      $display("FAIL mid_held: rd1=%h rd2=%h required 0 0", rd1, rd2);
    end
    @(negedge clk);
    reset = 1'b1;
    pop = 1'b1;
    ws = 3'd2;
    tick();
    rs1 = 3'd2;
    #1;
    checks++;
    if (rd1 !== 32'h0 || rd1 !== m_regs[2]) begin
      errors++;
      $display("FAIL mid_pop_empty: got %h required 0", rd1);
    end
    regwrite = 1'b1;
    ws = 3'd2;
    wd = 32'h5;
    tick();
    #1;
    checks++;
    if (rd1 !== 32'h5) begin
      errors++;
      $display("FAIL mid_recover: got %h required 5", rd1);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_stack_pop();
    test_empty_pop();
    test_overflow();
    test_push_pop();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
